// File: rtl/pet_stat_engine_pkg.sv
// pet_stat_engine_pkg: default configuration, item indices, kind enum and saturating arithmetic
package pet_stat_engine_pkg;
    localparam int P_N_STATS = 4;
    localparam int P_STAT_W = 3;
    localparam int P_STAT_MAX = 5;
    localparam int P_LOW_THRESH = 2;
    localparam int P_TICK_DIV = 25_000_000;
    localparam int P_DECAY_TICKS = 10;
    localparam int P_TICKS_PER_DAY = 20;
    localparam int P_DAY_W = 6;
    localparam int P_MAX_DAYS = 32;
    localparam int ITEM_DAYS = P_N_STATS;
    localparam int ITEM_MASK = P_N_STATS + 1;
    typedef enum logic [1:0] {K_STAT, K_DAYS, K_MASK} item_kind_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
    function automatic int sat_add(input int v, input int d, input int hi);
        int s;
        s = v + d;
        return s < 0 ? 0 : (s > hi ? hi : s);
    endfunction
    localparam int P_SEL_W = clog2(P_N_STATS + 2);
    localparam int P_VAL_W = P_STAT_W > P_DAY_W ? P_STAT_W : P_DAY_W;
endpackage

// File: rtl/pet_stat_engine_if.sv
// pet_stat_engine_if: pad/sensor inputs and display outputs of the stat engine
interface pet_stat_engine_if #(
    parameter int N_STATS = pet_stat_engine_pkg::P_N_STATS,
    parameter int SEL_W = pet_stat_engine_pkg::P_SEL_W,
    parameter int VAL_W = pet_stat_engine_pkg::P_VAL_W,
    parameter int DAY_W = pet_stat_engine_pkg::P_DAY_W
);
    logic test;
    logic btn_next;
    logic btn_back;
    logic btn_inc;
    logic btn_dec;
    logic [N_STATS-1:0] sns;
    logic [SEL_W-1:0] sel_idx;
    logic [VAL_W-1:0] sel_value;
    logic [N_STATS-1:0] ok_mask;
    logic [DAY_W-1:0] days;
    logic dead;
    logic tick;
    modport master (output test, btn_next, btn_back, btn_inc, btn_dec, sns,
                    input sel_idx, sel_value, ok_mask, days, dead, tick);
    modport slave (input test, btn_next, btn_back, btn_inc, btn_dec, sns,
                   output sel_idx, sel_value, ok_mask, days, dead, tick);
endinterface

// File: rtl/pet_stat_engine_btn_edge.sv
// pet_stat_engine_btn_edge: 2-flop synchroniser plus falling-edge detect on an active-low pad
module pet_stat_engine_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic pulse
);
    logic [2:0] sr;
    always_ff @(posedge clk) sr <= !rst ? 3'b111 : {sr[1:0], pad};
    assign pulse = sr[2] & ~sr[1];
endmodule

// File: rtl/pet_stat_engine.sv
// pet_stat_engine: saturating stat bank with decay/day schedule, cursor, death flag and registered outputs
module pet_stat_engine import pet_stat_engine_pkg::*; #(
    parameter int N_STATS = P_N_STATS,
    parameter int STAT_W = P_STAT_W,
    parameter int STAT_MAX = P_STAT_MAX,
    parameter int LOW_THRESH = P_LOW_THRESH,
    parameter int TICK_DIV = P_TICK_DIV,
    parameter int DECAY_TICKS = P_DECAY_TICKS,
    parameter int TICKS_PER_DAY = P_TICKS_PER_DAY,
    parameter int DAY_W = P_DAY_W,
    parameter int MAX_DAYS = P_MAX_DAYS
) (
    input logic clk,
    input logic rst,
    pet_stat_engine_if.slave bus
);
    localparam int SEL_W = clog2(N_STATS + 2);
    localparam int VAL_W = STAT_W > DAY_W ? STAT_W : DAY_W;
    localparam int IW = clog2(N_STATS);
    localparam int PW = clog2(TICK_DIV + 1);
    localparam int DW = clog2(DECAY_TICKS + 1);
    localparam int TW = clog2(TICKS_PER_DAY + 1);
    localparam int ITEM_D = N_STATS;
    localparam int ITEM_M = N_STATS + 1;
    logic p_next, p_back, p_inc, p_dec;
    logic [PW-1:0] presc;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic [STAT_W-1:0] stat [N_STATS];
    logic [STAT_W-1:0] stat_n [N_STATS];
    logic [DAY_W-1:0] days_q, days_n;
    logic dead_q, dead_n;
    logic [SEL_W-1:0] cur, cur_n;
    logic [N_STATS-1:0] ok_now;
    logic [VAL_W-1:0] val_now;
    logic signed [STAT_W+1:0] bdelta, dsum;
    logic tick_i, decay_ev, day_ev, all_zero;
    item_kind_t kind;
    pet_stat_engine_btn_edge u_next (.clk(clk), .rst(rst), .pad(bus.btn_next), .pulse(p_next));
    pet_stat_engine_btn_edge u_back (.clk(clk), .rst(rst), .pad(bus.btn_back), .pulse(p_back));
    pet_stat_engine_btn_edge u_inc (.clk(clk), .rst(rst), .pad(bus.btn_inc), .pulse(p_inc));
    pet_stat_engine_btn_edge u_dec (.clk(clk), .rst(rst), .pad(bus.btn_dec), .pulse(p_dec));
    assign tick_i = bus.test || presc == PW'(TICK_DIV - 1);
    assign decay_ev = tick_i && !dead_q && dcnt == DW'(DECAY_TICKS - 1);
    assign day_ev = tick_i && !dead_q && tcnt == TW'(TICKS_PER_DAY - 1);
    always_comb begin
        kind = cur < SEL_W'(N_STATS) ? K_STAT : (cur == SEL_W'(ITEM_D) ? K_DAYS : K_MASK);
        bdelta = (dead_q || p_inc == p_dec) ? (STAT_W+2)'(0) : (p_inc ? (STAT_W+2)'(1) : (STAT_W+2)'(-1));
        dsum = '0;
        all_zero = 1'b1;
        // button and decay deltas are summed first so coincident events are never lost
        for (int i = 0; i < N_STATS; i++) begin
            dsum = ((kind == K_STAT && cur == SEL_W'(i)) ? bdelta : (STAT_W+2)'(0))
                 + (decay_ev ? (bus.sns[i] ? (STAT_W+2)'(-1) : (STAT_W+2)'(1)) : (STAT_W+2)'(0));
            stat_n[i] = dead_q ? '0 : STAT_W'(sat_add(int'(stat[i]), int'(dsum), STAT_MAX));
            all_zero = all_zero && stat_n[i] == '0;
            ok_now[i] = !dead_q && stat[i] >= STAT_W'(LOW_THRESH);
        end
        days_n = dead_q ? days_q
               : DAY_W'(sat_add(int'(days_q), kind == K_DAYS ? int'(bdelta) : 0, MAX_DAYS - 1) + (day_ev ? 1 : 0));
        dead_n = dead_q || days_n == DAY_W'(MAX_DAYS) || all_zero;
        cur_n = (p_next && !p_back) ? (cur == SEL_W'(ITEM_M) ? '0 : cur + 1'b1)
              : (p_back && !p_next) ? (cur == '0 ? SEL_W'(ITEM_M) : cur - 1'b1) : cur;
        val_now = kind == K_STAT ? VAL_W'(stat[IW'(cur)]) : (kind == K_DAYS ? VAL_W'(days_q) : VAL_W'(ok_now));
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            dcnt <= '0;
            tcnt <= '0;
            cur <= '0;
            days_q <= '0;
            dead_q <= 1'b0;
            for (int i = 0; i < N_STATS; i++) stat[i] <= STAT_W'(STAT_MAX);
            bus.sel_value <= VAL_W'(STAT_MAX);
            bus.ok_mask <= '1;
            bus.tick <= 1'b0;
        end else begin
            presc <= presc == PW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
            if (tick_i && !dead_q) begin
                dcnt <= dcnt == DW'(DECAY_TICKS - 1) ? '0 : dcnt + 1'b1;
                tcnt <= tcnt == TW'(TICKS_PER_DAY - 1) ? '0 : tcnt + 1'b1;
            end
            stat <= stat_n;
            cur <= cur_n;
            days_q <= days_n;
            dead_q <= dead_n;
            bus.sel_value <= val_now;
            bus.ok_mask <= ok_now;
            bus.tick <= tick_i;
        end
    end
    assign bus.sel_idx = cur;
    assign bus.days = days_q;
    assign bus.dead = dead_q;
endmodule
